// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths, forwarding selector encoding and the control bundle layout
// for the ID/EX operand stage.
package id_ex_operand_stage_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CTRL_W = 8;

    localparam logic [REG_W-1:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_t;

    // Opaque to this stage; the field split only documents downstream use.
    typedef struct packed {
        logic [1:0] wb;
        logic [2:0] mem;
        logic [2:0] ex;
    } ctrl_t;

    function automatic logic [DATA_W-1:0] mux2(input logic [DATA_W-1:0] in0,
                                               input logic [DATA_W-1:0] in1,
                                               input logic              sel);
        return sel ? in1 : in0;
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-side, hazard-side and EX-side signals of the ID/EX operand stage.
interface id_ex_operand_stage_if;
    import id_ex_operand_stage_pkg::*;

    logic              id_valid;
    logic [REG_W-1:0]  id_rn;
    logic [REG_W-1:0]  id_rm;
    logic [DATA_W-1:0] id_rn_data;
    logic [DATA_W-1:0] id_rm_data;
    logic [DATA_W-1:0] id_imm;
    logic              id_alusrc;
    ctrl_t             id_ctrl;
    logic              stall;
    logic              flush;

    logic              exmem_regwrite;
    logic [REG_W-1:0]  exmem_rd;
    logic [DATA_W-1:0] exmem_result;
    logic              memwb_regwrite;
    logic [REG_W-1:0]  memwb_rd;
    logic [DATA_W-1:0] memwb_result;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_op_a;
    logic [DATA_W-1:0] ex_op_b_reg;
    logic [DATA_W-1:0] ex_imm;
    logic              ex_alusrc;
    ctrl_t             ex_ctrl;
    fwd_sel_t          fwd_a;
    fwd_sel_t          fwd_b;

    modport master (
        output id_valid, id_rn, id_rm, id_rn_data, id_rm_data, id_imm, id_alusrc, id_ctrl,
        output stall, flush,
        output exmem_regwrite, exmem_rd, exmem_result,
        output memwb_regwrite, memwb_rd, memwb_result,
        input  ex_valid, ex_op_a, ex_op_b_reg, ex_imm, ex_alusrc, ex_ctrl, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_rn_data, id_rm_data, id_imm, id_alusrc, id_ctrl,
        input  stall, flush,
        input  exmem_regwrite, exmem_rd, exmem_result,
        input  memwb_regwrite, memwb_rd, memwb_result,
        output ex_valid, ex_op_a, ex_op_b_reg, ex_imm, ex_alusrc, ex_ctrl, fwd_a, fwd_b
    );

endinterface

// File: rtl/id_ex_operand_stage_forwarding_unit.sv
// Picks the freshest producer of one source register: EX/MEM, then MEM/WB,
// else the register-file read captured in ID/EX.
module id_ex_operand_stage_forwarding_unit
    import id_ex_operand_stage_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             valid,
    input  logic             exmem_regwrite,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic             memwb_regwrite,
    input  logic [REG_W-1:0] memwb_rd,
    output fwd_sel_t         sel
);

    always_comb begin
        sel = FWD_REG;
        // XZR reads as zero no matter who claims to write it.
        if (valid && (src != XZR)) begin
            if (exmem_regwrite && (exmem_rd == src)) begin
                sel = FWD_EXMEM;
            end else if (memwb_regwrite && (memwb_rd == src)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding feeding
// ALU input A and both legs of the ALUSrc mux.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    id_ex_operand_stage_if.slave   bus
);

    logic              valid_q;
    logic [REG_W-1:0]  rn_q;
    logic [REG_W-1:0]  rm_q;
    logic [DATA_W-1:0] rn_data_q;
    logic [DATA_W-1:0] rm_data_q;
    logic [DATA_W-1:0] imm_q;
    logic              alusrc_q;
    ctrl_t             ctrl_q;

    fwd_sel_t          fwd_a;
    fwd_sel_t          fwd_b;
    logic [DATA_W-1:0] op_a_lvl1;
    logic [DATA_W-1:0] op_b_lvl1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            rn_q      <= '0;
            rm_q      <= '0;
            rn_data_q <= '0;
            rm_data_q <= '0;
            imm_q     <= '0;
            alusrc_q  <= 1'b0;
            ctrl_q    <= '0;
        end else if (bus.flush) begin
            // Data fields are don't-care once the slot is a bubble.
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (!bus.stall) begin
            valid_q   <= bus.id_valid;
            rn_q      <= bus.id_rn;
            rm_q      <= bus.id_rm;
            rn_data_q <= bus.id_rn_data;
            rm_data_q <= bus.id_rm_data;
            imm_q     <= bus.id_imm;
            alusrc_q  <= bus.id_alusrc;
            ctrl_q    <= bus.id_valid ? bus.id_ctrl : '0;
        end
    end

    id_ex_operand_stage_forwarding_unit u_fwd_a (
        .src            (rn_q),
        .valid          (valid_q),
        .exmem_regwrite (bus.exmem_regwrite),
        .exmem_rd       (bus.exmem_rd),
        .memwb_regwrite (bus.memwb_regwrite),
        .memwb_rd       (bus.memwb_rd),
        .sel            (fwd_a)
    );

    id_ex_operand_stage_forwarding_unit u_fwd_b (
        .src            (rm_q),
        .valid          (valid_q),
        .exmem_regwrite (bus.exmem_regwrite),
        .exmem_rd       (bus.exmem_rd),
        .memwb_regwrite (bus.memwb_regwrite),
        .memwb_rd       (bus.memwb_rd),
        .sel            (fwd_b)
    );

    // 3:1 select as two 2:1 levels; the one-hot encoding lets each bit steer a level.
    always_comb begin
        op_a_lvl1 = mux2(rn_data_q, bus.memwb_result, fwd_a[0]);
        op_b_lvl1 = mux2(rm_data_q, bus.memwb_result, fwd_b[0]);
    end

    assign bus.ex_op_a     = mux2(op_a_lvl1, bus.exmem_result, fwd_a[1]);
    assign bus.ex_op_b_reg = mux2(op_b_lvl1, bus.exmem_result, fwd_b[1]);
    assign bus.ex_valid    = valid_q;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_alusrc   = alusrc_q;
    assign bus.ex_ctrl     = ctrl_q;
    assign bus.fwd_a       = fwd_a;
    assign bus.fwd_b       = fwd_b;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: a mirror of the ID/EX contents
// predicts each cycle's outputs, which are queued and compared after the edge.
module tb_id_ex_operand_stage;
    import id_ex_operand_stage_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [63:0] op_a;
        logic [63:0] op_b;
        logic [63:0] imm;
        logic        alusrc;
        logic [7:0]  ctrl;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_operand_stage_if bus ();

    id_ex_operand_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t sb[$];
    exp_t e;
    exp_t g;

    logic        m_valid;
    logic [4:0]  m_rn;
    logic [4:0]  m_rm;
    logic [63:0] m_rnd;
    logic [63:0] m_rmd;
    logic [63:0] m_imm;
    logic        m_alusrc;
    logic [7:0]  m_ctrl;

    task automatic clear_mirror();
        m_valid = 0; m_rn = 0; m_rm = 0; m_rnd = 0; m_rmd = 0;
        m_imm = 0; m_alusrc = 0; m_ctrl = 0;
    endtask

    task automatic apply_edge();
        if (bus.flush) begin
            m_valid = 0;
            m_ctrl  = 0;
        end else if (!bus.stall) begin
            m_valid  = bus.id_valid;
            m_rn     = bus.id_rn;
            m_rm     = bus.id_rm;
            m_rnd    = bus.id_rn_data;
            m_rmd    = bus.id_rm_data;
            m_imm    = bus.id_imm;
            m_alusrc = bus.id_alusrc;
            m_ctrl   = bus.id_valid ? bus.id_ctrl : 8'h00;
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (!m_valid || src == 5'd31) return 2'b00;
        if (bus.exmem_regwrite && bus.exmem_rd == src) return 2'b10;
        if (bus.memwb_regwrite && bus.memwb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t predict();
        exp_t p;
        p.valid  = m_valid;
        p.fa     = ref_fwd(m_rn);
        p.fb     = ref_fwd(m_rm);
        p.op_a   = (p.fa == 2'b10) ? bus.exmem_result :
                   (p.fa == 2'b01) ? bus.memwb_result : m_rnd;
        p.op_b   = (p.fb == 2'b10) ? bus.exmem_result :
                   (p.fb == 2'b01) ? bus.memwb_result : m_rmd;
        p.imm    = m_imm;
        p.alusrc = m_alusrc;
        p.ctrl   = m_ctrl;
        return p;
    endfunction

    function automatic exp_t sample();
        exp_t s;
        s.valid  = bus.ex_valid;
        s.op_a   = bus.ex_op_a;
        s.op_b   = bus.ex_op_b_reg;
        s.imm    = bus.ex_imm;
        s.alusrc = bus.ex_alusrc;
        s.ctrl   = bus.ex_ctrl;
        s.fa     = bus.fwd_a;
        s.fb     = bus.fwd_b;
        return s;
    endfunction

    task automatic set_id(input logic v, input logic [4:0] rn, input logic [63:0] rnd,
                          input logic [4:0] rm, input logic [63:0] rmd, input logic [63:0] imm,
                          input logic alusrc, input logic [7:0] ctrl);
        bus.id_valid = v; bus.id_rn = rn; bus.id_rn_data = rnd; bus.id_rm = rm;
        bus.id_rm_data = rmd; bus.id_imm = imm; bus.id_alusrc = alusrc; bus.id_ctrl = ctrl;
    endtask

    task automatic set_haz(input logic exw, input logic [4:0] exrd, input logic [63:0] exres,
                           input logic mww, input logic [4:0] mwrd, input logic [63:0] mwres);
        bus.exmem_regwrite = exw; bus.exmem_rd = exrd; bus.exmem_result = exres;
        bus.memwb_regwrite = mww; bus.memwb_rd = mwrd; bus.memwb_result = mwres;
    endtask

    // Queue the post-edge prediction, then advance to just after the edge.
    task automatic step();
        apply_edge();
        sb.push_back(predict());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_mirror();
        sb.push_back('0);
        e = sb.pop_front(); g = sample(); tests_run++;
        if (g !== e) begin
            tests_failed++; $display("FAIL reset_held: got %h exp %h", g, e);
        end
        reset = 1'b1;
        #1;
        sb.push_back('0);
        e = sb.pop_front(); g = sample(); tests_run++;
        if (g !== e) begin
            tests_failed++; $display("FAIL reset_released: got %h exp %h", g, e);
        end
        bus.stall = 0; bus.flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_haz(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_capture();
        set_id(1, 5'd1, 64'd5, 5'd2, 64'd7, 64'd0, 0, 8'h5A);
        set_haz(0, 0, 64'h1234, 0, 0, 64'h5678);
        step();
        e = sb.pop_front(); g = sample(); tests_run++;
        if (g !== e || g.op_a !== 64'd5 || g.op_b !== 64'd7 || g.fa !== 2'b00 || g.fb !== 2'b00
            || g.ctrl !== 8'h5A || g.valid !== 1'b1) begin
            tests_failed++; $display("FAIL capture: got %h exp %h", g, e);
        end
    endtask

    task automatic test_exmem_priority();
        set_id(1, 5'd3, 64'h11, 5'd4, 64'h22, 64'd0, 0, 8'h81);
        set_haz(1, 5'd3, 64'hAA, 1, 5'd3, 64'hBB);
        step();
        e = sb.pop_front(); g = sample(); tests_run++;
        if (g !== e || g.op_a !== 64'hAA || g.fa !== 2'b10 || g.op_b !== 64'h22) begin
            tests_failed++; $display("FAIL exmem_priority: got %h exp %h", g, e);
        end
        bus.exmem_regwrite = 0;
        bus.memwb_rd = 5'd4;
        #1;
        sb.push_back(predict());
        e = sb.pop_front(); g = sample(); tests_run++;
        if (g !== e || g.op_a !== 64'h11 || g.op_b !== 64'hBB || g.fb !== 2'b01) begin
            tests_failed++; $display("FAIL memwb_fwd_b: got %h exp %h", g, e);
        end
        bus.memwb_rd = 5'd3;
        #1;
        sb.push_back(predict());
        e = sb.pop_front(); g = sample(); tests_run++;
        if (g !== e || g.op_a !== 64'hBB || g.fa !== 2'b01) begin
            tests_failed++; $display("FAIL memwb_fwd_a: got %h exp %h", g, e);
        end
    endtask

    task automatic test_xzr_and_bubble();
        set_id(1, 5'd31, 64'd0, 5'd31, 64'd0, 64'd0, 0, 8'h0F);
        set_haz(1, 5'd31, 64'hFF, 1, 5'd31, 64'hEE);
        step();
        e = sb.pop_front(); g = sample(); tests_run++;
        if (g !== e || g.op_b !== 64'd0 || g.fb !== 2'b00 || g.op_a !== 64'd0) begin
            tests_failed++; $display("FAIL xzr: got %h exp %h", g, e);
        end
        // A bubble must not forward or carry control even if its fields match.
        set_id(0, 5'd5, 64'd9, 5'd6, 64'd10, 64'd0, 0, 8'hC3);
        set_haz(1, 5'd5, 64'hAB, 1, 5'd6, 64'hCD);
        step();
        e = sb.pop_front(); g = sample(); tests_run++;
        if (g !== e || g.fa !== 2'b00 || g.fb !== 2'b00 || g.op_a !== 64'd9
            || g.ctrl !== 8'h00 || g.valid !== 1'b0) begin
            tests_failed++; $display("FAIL bubble: got %h exp %h", g, e);
        end
    endtask

    task automatic test_stall_flush();
        set_id(1, 5'd1, 64'h100, 5'd2, 64'h200, 64'h44, 1, 8'h33);
        set_haz(0, 0, 64'h1, 0, 0, 64'h2);
        step();
        e = sb.pop_front(); g = sample(); tests_run++;
        if (g !== e) begin
            tests_failed++; $display("FAIL stall_setup: got %h exp %h", g, e);
        end
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 5'd7 + 5'(i), 64'h900 + 64'(i), 5'd8, 64'h999, 64'h55, 0, 8'hEE);
            if (i == 2) set_haz(1, 5'd1, 64'h777, 0, 0, 64'h2);
            step();
            e = sb.pop_front(); g = sample(); tests_run++;
            if (g !== e || g.imm !== 64'h44 || g.ctrl !== 8'h33
                || g.op_a !== ((i == 2) ? 64'h777 : 64'h100)) begin
                tests_failed++; $display("FAIL stall_hold_%0d: got %h exp %h", i, g, e);
            end
        end
        bus.flush = 1;
        step();
        e = sb.pop_front(); g = sample(); tests_run++;
        if (g !== e || g.valid !== 1'b0 || g.ctrl !== 8'h00 || g.fa !== 2'b00) begin
            tests_failed++; $display("FAIL stall_flush: got %h exp %h", g, e);
        end
        bus.stall = 0; bus.flush = 0;
        step();
        e = sb.pop_front(); g = sample(); tests_run++;
        if (g !== e || g.valid !== 1'b1 || g.ctrl !== 8'hEE) begin
            tests_failed++; $display("FAIL resume: got %h exp %h", g, e);
        end
    endtask

    task automatic test_imm_async_reset();
        set_id(1, 5'd2, 64'h3, 5'd4, 64'h5, 64'h10, 1, 8'h99);
        set_haz(0, 0, 0, 0, 0, 0);
        step();
        e = sb.pop_front(); g = sample(); tests_run++;
        if (g !== e || g.alusrc !== 1'b1 || g.imm !== 64'h10) begin
            tests_failed++; $display("FAIL imm_alusrc: got %h exp %h", g, e);
        end
        reset = 1'b0;
        #1;
        clear_mirror();
        sb.push_back(predict());
        e = sb.pop_front(); g = sample(); tests_run++;
        if (g !== e || g.valid !== 1'b0 || g !== exp_t'(0)) begin
            tests_failed++; $display("FAIL async_reset: got %h exp %h", g, e);
        end
        #2;
        reset = 1'b1;
        step();
        e = sb.pop_front(); g = sample(); tests_run++;
        if (g !== e || g.valid !== 1'b1 || g.imm !== 64'h10) begin
            tests_failed++; $display("FAIL post_reset_capture: got %h exp %h", g, e);
        end
    endtask

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    task automatic test_back_to_back();
        logic [4:0] rn;
        logic [4:0] rm;
        for (int i = 0; i < 200; i++) begin
            rn = pick_reg();
            rm = pick_reg();
            set_id(1'($urandom_range(0, 3) != 0), rn,
                   (rn == 5'd31) ? 64'd0 : {$urandom, $urandom}, rm,
                   (rm == 5'd31) ? 64'd0 : {$urandom, $urandom},
                   {$urandom, $urandom}, 1'($urandom_range(0, 1)), 8'($urandom));
            set_haz(1'($urandom_range(0, 1)), pick_reg(), {$urandom, $urandom},
                    1'($urandom_range(0, 1)), pick_reg(), {$urandom, $urandom});
            bus.stall = ($urandom_range(0, 5) == 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            step();
            e = sb.pop_front(); g = sample(); tests_run++;
            if (g !== e) begin
                tests_failed++; $display("FAIL back_to_back_%0d: got %h exp %h", i, g, e);
            end
        end
        bus.stall = 0; bus.flush = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_capture();
        test_exmem_priority();
        test_xzr_and_bubble();
        test_stall_flush();
        test_imm_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
